// File: rtl/mycpu_seq_ctrl.sv
// Multi-cycle MIPS sequencer: fetch, decode, execute, memory and write-back
// control with memory handshakes, retired-instruction counting and ack timeout.
module mycpu_seq_ctrl #(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             is_branch,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             rf_wen,
    output logic             wb_sel_mem,
    output logic             retire,
    output logic [CNT_W-1:0] inst_count,
    output logic             err,
    output logic [2:0]       state
);

    // state   | meaning
    // IDLE    | post-reset, heads to FETCH
    // FETCH   | imem request outstanding, waiting for imem_ack
    // DECODE  | latch instruction class
    // EXEC    | ALU / branch resolve; branches retire here
    // MEM     | dmem request outstanding; stores retire on ack
    // WB      | register write-back, retire
    // ERR     | handshake timeout, parked until reset

    localparam int WAIT_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_LOAD   = 2'd1,
        CLS_STORE  = 2'd2,
        CLS_BRANCH = 2'd3
    } cls_t;

    state_t            state_q;
    cls_t              cls_q;
    logic [WAIT_W-1:0] wait_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              timed_out;

    // The ack is checked before the limit, so a last-cycle ack still wins.
    assign timed_out = (wait_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_ALU;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    wait_q  <= '0;
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state_q <= S_DECODE;
                    end else if (timed_out) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (is_branch)     cls_q <= CLS_BRANCH;
                    else if (is_store) cls_q <= CLS_STORE;
                    else if (is_load)  cls_q <= CLS_LOAD;
                    else               cls_q <= CLS_ALU;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    wait_q <= '0;
                    case (cls_q)
                        CLS_BRANCH: state_q <= S_FETCH;
                        CLS_LOAD,
                        CLS_STORE:  state_q <= S_MEM;
                        default:    state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        wait_q  <= '0;
                        state_q <= (cls_q == CLS_STORE) ? S_FETCH : S_WB;
                    end else if (timed_out) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    wait_q  <= '0;
                    state_q <= S_FETCH;
                end
                S_ERR: begin
                    state_q <= S_ERR;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are suppressed while rst is high so an abandoned instruction never retires.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        rf_wen     = 1'b0;
        wb_sel_mem = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_EXEC: begin
                    if (cls_q == CLS_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls_q == CLS_STORE);
                    if (cls_q == CLS_STORE && dmem_ack) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    rf_wen     = 1'b1;
                    wb_sel_mem = (cls_q == CLS_LOAD);
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign err        = err_q;
    assign inst_count = cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mycpu_seq_ctrl.sv
// Self-checking bench for mycpu_seq_ctrl: fixed vector table plus randomized
// instruction streams expanded into per-cycle expectations from the sequencing rules.
module tb_mycpu_seq_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [9:0] O_IREQ = 10'b1000000000;
    localparam logic [9:0] O_DREQ = 10'b0100000000;
    localparam logic [9:0] O_DWE  = 10'b0010000000;
    localparam logic [9:0] O_IRWE = 10'b0001000000;
    localparam logic [9:0] O_PCWE = 10'b0000100000;
    localparam logic [9:0] O_PCSL = 10'b0000010000;
    localparam logic [9:0] O_RFW  = 10'b0000001000;
    localparam logic [9:0] O_WBM  = 10'b0000000100;
    localparam logic [9:0] O_RET  = 10'b0000000010;
    localparam logic [9:0] O_ERR  = 10'b0000000001;

    typedef struct {
        logic          rst;
        logic          ia;
        logic          da;
        logic          br;
        logic          ld;
        logic          sw;
        logic          tk;
        logic [2:0]    es;
        logic [9:0]    eo;
        logic [CW-1:0] ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst, imem_ack, dmem_ack, is_branch, is_load, is_store, branch_taken;
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_wen, wb_sel_mem, retire, err;
    logic [CW-1:0] inst_count;
    logic [2:0]    state;
    logic [9:0]    act_o;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    vec_t tbl[8];
    vec_t q[$];

    always #5 clk = ~clk;

    assign act_o = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_wen, wb_sel_mem, retire, err};

    mycpu_seq_ctrl #(.ACK_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .is_branch(is_branch), .is_load(is_load), .is_store(is_store),
        .branch_taken(branch_taken), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .rf_wen(rf_wen), .wb_sel_mem(wb_sel_mem), .retire(retire),
        .inst_count(inst_count), .err(err), .state(state)
    );

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic vec_t mk(logic r, logic ia, logic da, logic br, logic ld, logic sw,
                                logic tk, logic [2:0] s, logic [9:0] o, int c);
        vec_t v;
        v.rst = r; v.ia = ia; v.da = da; v.br = br; v.ld = ld; v.sw = sw; v.tk = tk;
        v.es = s; v.eo = o; v.ec = CW'(c);
        return v;
    endfunction

    function automatic void bump();
        exp_cnt = (exp_cnt + 1) % (1 << CW);
    endfunction

    // Instruction classes in the model: 0 ALU, 1 load, 2 store, 3 branch
    function automatic int cls_of(logic br, logic ld, logic sw);
        if (br) return 3;
        if (sw) return 2;
        if (ld) return 1;
        return 0;
    endfunction

    function automatic void push_fetch(int di);
        for (int k = 0; k <= di; k++)
            q.push_back(mk(0, k == di, rnd(), rnd(), rnd(), rnd(), rnd(), 3'd1,
                           O_IREQ | ((k == di) ? O_IRWE : 10'b0), exp_cnt));
    endfunction

    function automatic void push_decode(logic br, logic ld, logic sw);
        q.push_back(mk(0, rnd(), rnd(), br, ld, sw, rnd(), 3'd2, 10'b0, exp_cnt));
    endfunction

    function automatic void push_exec(int cls, logic tk);
        if (cls == 3) begin
            q.push_back(mk(0, rnd(), rnd(), rnd(), rnd(), rnd(), tk, 3'd3,
                           O_PCWE | (tk ? O_PCSL : 10'b0) | O_RET, exp_cnt));
            bump();
        end else begin
            q.push_back(mk(0, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 3'd3, 10'b0, exp_cnt));
        end
    endfunction

    function automatic void push_mem(int cls, int dm);
        for (int k = 0; k <= dm; k++) begin
            logic [9:0] o;
            o = O_DREQ;
            if (cls == 2) o = o | O_DWE;
            if (cls == 2 && k == dm) o = o | O_PCWE | O_RET;
            q.push_back(mk(0, rnd(), k == dm, rnd(), rnd(), rnd(), rnd(), 3'd4, o, exp_cnt));
            if (cls == 2 && k == dm) bump();
        end
    endfunction

    function automatic void push_wb(int cls);
        q.push_back(mk(0, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 3'd5,
                       O_RFW | ((cls == 1) ? O_WBM : 10'b0) | O_PCWE | O_RET, exp_cnt));
        bump();
    endfunction

    function automatic void gen_instr(logic br, logic ld, logic sw, logic tk, int di, int dm);
        int cls;
        cls = cls_of(br, ld, sw);
        push_fetch(di);
        push_decode(br, ld, sw);
        push_exec(cls, tk);
        if (cls == 1 || cls == 2) push_mem(cls, dm);
        if (cls == 0 || cls == 1) push_wb(cls);
    endfunction

    function automatic void push_rst(logic [2:0] s, logic in_err);
        q.push_back(mk(1, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), s,
                       in_err ? O_ERR : 10'b0, exp_cnt));
        exp_cnt = 0;
        q.push_back(mk(0, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 3'd0, 10'b0, exp_cnt));
    endfunction

    task automatic apply(input vec_t v, input int idx);
        rst = v.rst; imem_ack = v.ia; dmem_ack = v.da;
        is_branch = v.br; is_load = v.ld; is_store = v.sw; branch_taken = v.tk;
        @(negedge clk);
        total++;
        if (state !== v.es || act_o !== v.eo || inst_count !== v.ec) begin
            bad++;
            $display("FAIL vec%0d: got state=%0d outs=%b cnt=%0d, want state=%0d outs=%b cnt=%0d",
                     idx, state, act_o, inst_count, v.es, v.eo, v.ec);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then one ALU op with acks tied high, then reset during FETCH
        tbl[0] = mk(0, 1, 1, 0, 0, 0, 0, 3'd0, 10'b0, 0);
        tbl[1] = mk(0, 1, 1, 0, 0, 0, 0, 3'd1, O_IREQ | O_IRWE, 0);
        tbl[2] = mk(0, 1, 1, 0, 0, 0, 0, 3'd2, 10'b0, 0);
        tbl[3] = mk(0, 1, 1, 0, 0, 0, 0, 3'd3, 10'b0, 0);
        tbl[4] = mk(0, 1, 1, 0, 0, 0, 0, 3'd5, O_RFW | O_PCWE | O_RET, 0);
        tbl[5] = mk(0, 0, 1, 0, 0, 0, 0, 3'd1, O_IREQ, 1);
        tbl[6] = mk(1, 0, 1, 0, 0, 0, 0, 3'd1, 10'b0, 1);
        tbl[7] = mk(0, 0, 1, 0, 0, 0, 0, 3'd0, 10'b0, 0);

        rst = 1; imem_ack = 0; dmem_ack = 0;
        is_branch = 0; is_load = 0; is_store = 0; branch_taken = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) apply(tbl[i], i);
        exp_cnt = 0;

        gen_instr(0, 1, 0, 0, 0, 3);
        gen_instr(1, 0, 0, 1, 0, 0);
        gen_instr(1, 0, 0, 0, 2, 0);
        gen_instr(0, 1, 1, 0, 1, 1);
        gen_instr(0, 0, 0, 1, TO - 1, 0);
        gen_instr(0, 1, 0, 0, 0, TO - 1);
        for (int n = 0; n < 30; n++)
            gen_instr(rnd(), rnd(), rnd(), rnd(), $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1));

        for (int k = 0; k < TO; k++)
            q.push_back(mk(0, 0, rnd(), rnd(), rnd(), rnd(), rnd(), 3'd1, O_IREQ, exp_cnt));
        for (int k = 0; k < 20; k++)
            q.push_back(mk(0, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 3'd6, O_ERR, exp_cnt));
        push_rst(3'd6, 1'b1);

        gen_instr(0, 0, 0, 0, 1, 0);
        push_fetch(0);
        push_decode(0, 0, 1);
        push_exec(2, 0);
        q.push_back(mk(0, rnd(), 0, rnd(), rnd(), rnd(), rnd(), 3'd4, O_DREQ | O_DWE, exp_cnt));
        q.push_back(mk(1, rnd(), 1, rnd(), rnd(), rnd(), rnd(), 3'd4, 10'b0, exp_cnt));
        exp_cnt = 0;
        q.push_back(mk(0, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 3'd0, 10'b0, exp_cnt));
        for (int n = 0; n < 16; n++)
            gen_instr(0, 0, 0, rnd(), $urandom_range(0, TO - 1), 0);
        q.push_back(mk(0, 0, rnd(), rnd(), rnd(), rnd(), rnd(), 3'd1, O_IREQ, exp_cnt));

        for (int i = 0; i < q.size(); i++) apply(q[i], 8 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mycpu_seq_ctrl.md
Name: mycpu_seq_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath: fetch, decode/register-file read, ALU, data memory and register write-back.
- Runs each instruction through a state machine.
- Handshakes with instruction and data memory.
- Drives the IR, PC, register-file write and writeback-select strobes from the decoder's class flags.
- Counts retired instructions.
- Flags a memory handshake timeout.

Parameters:
- ACK_TIMEOUT, 255, wait cycles allowed in FETCH or MEM before the timeout error fires; must be ≥1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all logic updates on the rising edge
- rst  in  1  synchronous, active-high reset
- imem_ack  in  1  instruction memory data valid this cycle
- dmem_ack  in  1  data memory access complete this cycle
- is_branch  in  1  decoded branch class (beq/bne/blez/bgtz)
- is_load  in  1  decoded lw
- is_store  in  1  decoded sw
- branch_taken  in  1  branch condition result, valid in EXEC
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable, qualified by dmem_req
- ir_we  out  1  latch the fetched instruction
- pc_we  out  1  update PC
- pc_sel  out  1  0 = PC+4, 1 = branch target; qualified by pc_we
- rf_wen  out  1  register-file write enable
- wb_sel_mem  out  1  write-back source: 1 = memory data, 0 = ALU; qualified by rf_wen
- retire  out  1  one-cycle pulse per completed instruction
- inst_count  out  CNT_W  retired-instruction count
- err  out  1  sticky handshake-timeout flag
- state  out  3  current state encoding, for debug

Behaviour:
- Reset:
  - rst sampled high at an edge: state ← IDLE, inst_count ← 0, err ← 0, wait counter ← 0, latched class ← ALU.
  - The cycle after reset, every output is 0.
  - Reset mid-operation abandons the instruction. No pc_we, rf_wen or retire is issued for it.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
- All outputs are Moore outputs, decoded from the registered state and latched class.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH:
  - imem_req=1 every cycle in FETCH.
  - imem_ack=1: ir_we=1 in that same cycle; next state DECODE.
  - Otherwise the wait counter increments.
- DECODE:
  - Sample is_branch, is_load and is_store into the class register.
  - Priority when more than one flag is set: branch > store > load > ALU.
  - Next state EXEC.
  - Later changes on the class inputs are ignored until the next DECODE.
- EXEC, by latched class:
  - Branch: pc_we=1, pc_sel=branch_taken, retire=1; next state FETCH.
  - Load or store: next state MEM.
  - ALU: next state WB.
- MEM:
  - dmem_req=1, and dmem_we=1 for store only.
  - Store with dmem_ack: pc_we=1, pc_sel=0, retire=1; next state FETCH.
  - Load with dmem_ack: next state WB.
  - Otherwise the wait counter increments.
- WB:
  - rf_wen=1; wb_sel_mem=1 for load, 0 for ALU.
  - pc_we=1, pc_sel=0, retire=1.
  - Next state FETCH.
- Wait counter:
  - Cleared on entry to FETCH and to MEM.
  - If it reaches ACK_TIMEOUT with no ack, next state is ERR.
  - An ack arriving in the same cycle as the limit is reached wins: normal transition, no error.
- ERR:
  - err=1, all request and strobe outputs 0.
  - Remains in ERR until rst.
- Acks outside their own state (imem_ack outside FETCH, dmem_ack outside MEM) are ignored.
- inst_count increments by 1 on each retire and wraps from 2^CNT_W−1 to 0.
- Latency with zero-wait acks (acked in the first request cycle), FETCH entry to retire cycle inclusive:
  - Branch: 3 cycles.
  - ALU: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Test Plan:
- Reset then ALU op (all class flags 0), acks tied 1 → state sequence 0,1,2,3,5,1. rf_wen=1 and wb_sel_mem=0 in WB. retire pulses in WB. inst_count=1.
- Load with dmem_ack delayed 3 cycles in MEM → dmem_req high 4 cycles with dmem_we=0. Then WB with wb_sel_mem=1. Retire 8 cycles after FETCH entry.
- Taken branch followed by not-taken branch → pc_we=1 in EXEC with pc_sel=1, then pc_sel=0. No rf_wen either time. inst_count=2.
- is_load=1 and is_store=1 together in DECODE → treated as store: dmem_we=1, no WB state, rf_wen never asserted.
- ACK_TIMEOUT=4, imem_ack held 0 → ERR entered after 4 wait cycles; err=1, imem_req=0. Stays in ERR for 20 cycles. rst clears err.
- rst pulsed during MEM, then CNT_W=4 and 16 ALU ops → no retire for the aborted op. After the 16 ops inst_count wraps to 0.
